// File: rtl/common_pseudo_lru_alloc_ctrl_if.sv
// rtl/common_pseudo_lru_alloc_ctrl_if.sv - touch/invalidate/allocate and pick-block bundle for the pLRU allocator
interface common_pseudo_lru_alloc_ctrl_if #(
    parameter int SUBJECT_COUNT_LOG2 = 1
);
    localparam int L = SUBJECT_COUNT_LOG2;
    localparam int P = 1 << SUBJECT_COUNT_LOG2;

    logic [L-1:0] touch_addr;
    logic         touch_en;
    logic         touch_ready;
    logic [L-1:0] inval_addr;
    logic         inval_en;
    logic         inval_all;
    logic         alloc_req;
    logic         alloc_ack;
    logic [L-1:0] alloc_addr;
    logic [P-1:0] valid_q;
    logic [L-1:0] lru_waddr;
    logic         lru_wen;
    logic [P-1:0] lru_dvalid;
    logic [L-1:0] lru_qaddr;
    logic         lru_qvalid;

    // master: requester plus pick block; slave: the allocation controller
    modport master (
        output touch_addr, touch_en, inval_addr, inval_en, inval_all, alloc_req,
               lru_qaddr, lru_qvalid,
        input  touch_ready, alloc_ack, alloc_addr, valid_q, lru_waddr, lru_wen, lru_dvalid
    );

    modport slave (
        input  touch_addr, touch_en, inval_addr, inval_en, inval_all, alloc_req,
               lru_qaddr, lru_qvalid,
        output touch_ready, alloc_ack, alloc_addr, valid_q, lru_waddr, lru_wen, lru_dvalid
    );
endinterface

// File: rtl/common_pseudo_lru_alloc_ctrl.sv
// rtl/common_pseudo_lru_alloc_ctrl.sv - entry allocator: fills invalid entries first, then evicts the pLRU victim
module common_pseudo_lru_alloc_ctrl #(
    parameter int SUBJECT_COUNT_LOG2 = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    common_pseudo_lru_alloc_ctrl_if.slave    bus
);
    localparam int L = SUBJECT_COUNT_LOG2;
    localparam int P = 1 << SUBJECT_COUNT_LOG2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PICK  = 2'd1;
    localparam logic [1:0] GRANT = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [L-1:0] victim_q, victim_d;
    logic         ack_q, ack_d;
    logic [P-1:0] valid_q, valid_d;
    logic [L-1:0] free_idx;
    logic         any_free;
    logic         grant;
    logic         touch_acc;

    // Lowest-index invalid entry: scan high to low so the last hit wins.
    always_comb begin
        free_idx = '0;
        for (int i = P - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = L'(i);
        end
        any_free = ~&valid_q;
    end

    assign grant     = (state_q == GRANT);
    assign touch_acc = bus.touch_en && !grant;

    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        ack_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.alloc_req) state_d = PICK;
            end
            PICK: begin
                if (!bus.alloc_req) begin
                    state_d = IDLE;
                end else if (any_free) begin
                    victim_d = free_idx;
                    state_d  = GRANT;
                    ack_d    = 1'b1;
                end else if (bus.lru_qvalid) begin
                    victim_d = bus.lru_qaddr;
                    state_d  = GRANT;
                    ack_d    = 1'b1;
                end
            end
            GRANT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Clears first, then the grant's set, so a same-cycle grant keeps its entry valid.
    always_comb begin
        valid_d = valid_q;
        if (bus.inval_all) valid_d = '0;
        if (bus.inval_en) valid_d[bus.inval_addr] = 1'b0;
        if (grant) valid_d[victim_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            victim_q <= '0;
            ack_q    <= 1'b0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            ack_q    <= ack_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.touch_ready = !grant;
    assign bus.alloc_ack   = ack_q;
    assign bus.alloc_addr  = victim_q;
    assign bus.valid_q     = valid_q;
    assign bus.lru_dvalid  = valid_q;
    assign bus.lru_wen     = grant || touch_acc;
    assign bus.lru_waddr   = grant ? victim_q : bus.touch_addr;
endmodule
